// File: rtl/mod_mem_arbiter_pkg.sv
// Shared types for the two-client main-memory arbiter: default bus widths,
// FSM state and client encodings.
package mod_mem_arbiter_pkg;

  localparam int MEM_XLEN = 32;
  localparam int MEM_BE_W = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT_INST = 2'd1,
    GRANT_DATA = 2'd2
  } arb_state_e;

  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } arb_client_e;

  function automatic arb_state_e grant_state(input arb_client_e client);
    return (client == DATA) ? GRANT_DATA : GRANT_INST;
  endfunction

endpackage

// File: rtl/mod_mem_arbiter_if.sv
// Level-request memory bus used on both the client side and the memory side
// of the arbiter.
//
// Handshake: the master raises read and/or write together with address,
// writedata and byteenable, and holds them stable until the slave pulses
// operation_stb for one cycle. readdata is only meaningful in that strobe
// cycle. The master drops its request in the cycle after the strobe; dropping
// it earlier abandons the operation.
interface mod_mem_arbiter_if
  import mod_mem_arbiter_pkg::*;
#(
  parameter int XLEN = MEM_XLEN,
  parameter int BE_W = MEM_BE_W
);

  logic [XLEN-1:0] address;
  logic [XLEN-1:0] writedata;
  logic            read;
  logic            write;
  logic [BE_W-1:0] byteenable;
  logic [XLEN-1:0] readdata;
  logic            operation_stb;

  modport master (
    output address, writedata, read, write, byteenable,
    input  readdata, operation_stb
  );

  modport slave (
    input  address, writedata, read, write, byteenable,
    output readdata, operation_stb
  );

endinterface

// File: rtl/mod_mem_arbiter_mux.sv
// Combinational routing for the arbiter: forwards the granted client's bus to
// memory and returns the memory strobe to that client only.
module mod_mem_arbiter_mux
  import mod_mem_arbiter_pkg::*;
(
  input  arb_state_e         state_i,
  mod_mem_arbiter_if.slave   inst_if,
  mod_mem_arbiter_if.slave   data_if,
  mod_mem_arbiter_if.master  mem_if
);

  always_comb begin
    mem_if.address        = '0;
    mem_if.writedata      = '0;
    mem_if.read           = 1'b0;
    mem_if.write          = 1'b0;
    mem_if.byteenable     = '0;
    inst_if.operation_stb = 1'b0;
    data_if.operation_stb = 1'b0;
    case (state_i)
      GRANT_INST: begin
        mem_if.address        = inst_if.address;
        mem_if.writedata      = inst_if.writedata;
        mem_if.read           = inst_if.read;
        mem_if.write          = inst_if.write;
        mem_if.byteenable     = inst_if.byteenable;
        inst_if.operation_stb = mem_if.operation_stb;
      end
      GRANT_DATA: begin
        mem_if.address        = data_if.address;
        mem_if.writedata      = data_if.writedata;
        mem_if.read           = data_if.read;
        mem_if.write          = data_if.write;
        mem_if.byteenable     = data_if.byteenable;
        data_if.operation_stb = mem_if.operation_stb;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; only the routed strobe marks it valid.
  assign inst_if.readdata = mem_if.readdata;
  assign data_if.readdata = mem_if.readdata;

endmodule

// File: rtl/mod_mem_arbiter.sv
// Two-client main-memory arbiter (I-cache / D-cache). Holds a grant until
// memory completes or the client abandons. Define MEM_ARBITER_ROUND_ROBIN_EN
// for round-robin tie breaking; the default is fixed data-over-instruction.
module mod_mem_arbiter
  import mod_mem_arbiter_pkg::*;
#(
  parameter int XLEN             = MEM_XLEN,
  parameter int BYTEENABLE_WIDTH = MEM_BE_W
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [XLEN-1:0]             inst_address_i,
  input  logic                        inst_read_i,
  output logic [XLEN-1:0]             inst_readdata_o,
  output logic                        inst_operation_stb_o,
  input  logic [XLEN-1:0]             data_address_i,
  input  logic [XLEN-1:0]             data_writedata_i,
  input  logic                        data_read_i,
  input  logic                        data_write_i,
  input  logic [BYTEENABLE_WIDTH-1:0] data_byteenable_i,
  output logic [XLEN-1:0]             data_readdata_o,
  output logic                        data_operation_stb_o,
  input  logic [XLEN-1:0]             memory_readdata_i,
  input  logic                        memory_operation_stb_i,
  output logic [XLEN-1:0]             memory_address_o,
  output logic [XLEN-1:0]             memory_writedata_o,
  output logic                        memory_read_o,
  output logic                        memory_write_o,
  output logic [BYTEENABLE_WIDTH-1:0] memory_byteenable_o
);

  mod_mem_arbiter_if #(.XLEN(XLEN), .BE_W(BYTEENABLE_WIDTH)) inst_bus ();
  mod_mem_arbiter_if #(.XLEN(XLEN), .BE_W(BYTEENABLE_WIDTH)) data_bus ();
  mod_mem_arbiter_if #(.XLEN(XLEN), .BE_W(BYTEENABLE_WIDTH)) mem_bus ();

  // The I-cache only reads: present it as a full-word read-only client.
  assign inst_bus.address    = inst_address_i;
  assign inst_bus.writedata  = '0;
  assign inst_bus.read       = inst_read_i;
  assign inst_bus.write      = 1'b0;
  assign inst_bus.byteenable = '1;
  assign inst_readdata_o      = inst_bus.readdata;
  assign inst_operation_stb_o = inst_bus.operation_stb;

  assign data_bus.address    = data_address_i;
  assign data_bus.writedata  = data_writedata_i;
  assign data_bus.read       = data_read_i;
  assign data_bus.write      = data_write_i;
  assign data_bus.byteenable = data_byteenable_i;
  assign data_readdata_o      = data_bus.readdata;
  assign data_operation_stb_o = data_bus.operation_stb;

  assign mem_bus.readdata      = memory_readdata_i;
  assign mem_bus.operation_stb = memory_operation_stb_i;
  assign memory_address_o    = mem_bus.address;
  assign memory_writedata_o  = mem_bus.writedata;
  assign memory_read_o       = mem_bus.read;
  assign memory_write_o      = mem_bus.write;
  assign memory_byteenable_o = mem_bus.byteenable;

  logic        req_inst;
  logic        req_data;
  arb_client_e winner;
  arb_state_e  state_q;

  assign req_inst = inst_read_i;
  assign req_data = data_read_i | data_write_i;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  arb_client_e last_grant_q;

  // On a tie the client that was not served last wins.
  always_comb begin
    winner = req_data ? DATA : INST;
    if (req_inst && req_data) begin
      winner = (last_grant_q == INST) ? DATA : INST;
    end
  end
`else
  always_comb begin
    winner = req_data ? DATA : INST;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last_grant_q <= INST;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_inst || req_data) begin
            state_q <= grant_state(winner);
          end
        end
        GRANT_INST: begin
          // Completion and abandonment both release the port.
          if (!req_inst || memory_operation_stb_i) begin
            state_q <= IDLE;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_grant_q <= INST;
`endif
          end
        end
        GRANT_DATA: begin
          if (!req_data || memory_operation_stb_i) begin
            state_q <= IDLE;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_grant_q <= DATA;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  mod_mem_arbiter_mux u_mux (
    .state_i (state_q),
    .inst_if (inst_bus.slave),
    .data_if (data_bus.slave),
    .mem_if  (mem_bus.master)
  );

endmodule

// File: tb/tb_mod_mem_arbiter.sv
// Bench for mod_mem_arbiter: directed scenarios followed by randomized
// traffic checked against a grant-ownership reference model.
module tb_mod_mem_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] inst_addr;
  logic        inst_read;
  logic [31:0] inst_rd;
  logic        inst_stb;
  logic [31:0] data_addr;
  logic [31:0] data_wd;
  logic        data_read;
  logic        data_write;
  logic [3:0]  data_be;
  logic [31:0] data_rd;
  logic        data_stb;

  mod_mem_arbiter_if mem_if ();

  mod_mem_arbiter dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .inst_address_i         (inst_addr),
    .inst_read_i            (inst_read),
    .inst_readdata_o        (inst_rd),
    .inst_operation_stb_o   (inst_stb),
    .data_address_i         (data_addr),
    .data_writedata_i       (data_wd),
    .data_read_i            (data_read),
    .data_write_i           (data_write),
    .data_byteenable_i      (data_be),
    .data_readdata_o        (data_rd),
    .data_operation_stb_o   (data_stb),
    .memory_readdata_i      (mem_if.readdata),
    .memory_operation_stb_i (mem_if.operation_stb),
    .memory_address_o       (mem_if.address),
    .memory_writedata_o     (mem_if.writedata),
    .memory_read_o          (mem_if.read),
    .memory_write_o         (mem_if.write),
    .memory_byteenable_o    (mem_if.byteenable)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  typedef logic [71:0] obs_t;

  function automatic obs_t obs();
    return {mem_if.address, mem_if.writedata, mem_if.read, mem_if.write,
            mem_if.byteenable, inst_stb, data_stb};
  endfunction

  function automatic obs_t mk(input logic [31:0] a, input logic [31:0] wd,
                              input logic rd, input logic wr, input logic [3:0] be,
                              input logic is, input logic ds);
    return {a, wd, rd, wr, be, is, ds};
  endfunction

  // Reference model: which client owns the port (0 none, 1 inst, 2 data).
  int m_owner;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  int m_last;
`endif

  function automatic obs_t model_out();
    case (m_owner)
      1: return mk(inst_addr, 32'h0, inst_read, 1'b0, 4'hF, mem_if.operation_stb, 1'b0);
      2: return mk(data_addr, data_wd, data_read, data_write, data_be, 1'b0, mem_if.operation_stb);
      default: return '0;
    endcase
  endfunction

  function automatic void model_tick();
    bit ri;
    bit rq;
    bit still;
    ri = inst_read;
    rq = data_read | data_write;
    if (rst) begin
      m_owner = 0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      m_last = 1;
`endif
    end else if (m_owner == 0) begin
      if (ri && rq) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        m_owner = (m_last == 2) ? 1 : 2;
`else
        m_owner = 2;
`endif
      end else if (rq) m_owner = 2;
      else if (ri) m_owner = 1;
    end else begin
      still = (m_owner == 1) ? ri : rq;
      if (!still || mem_if.operation_stb) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        m_last = m_owner;
`endif
        m_owner = 0;
      end
    end
  endfunction

  // driver tasks
  task automatic drive_quiet();
    inst_read = 1'b0;
    data_read = 1'b0;
    data_write = 1'b0;
    mem_if.operation_stb = 1'b0;
    mem_if.readdata = 32'h0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    data_read = 1'b1;
    data_addr = 32'h0000_0040;
    @(negedge clk);
    @(negedge clk);
    #1;
    total++;
    if (obs() !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=%h", obs(), 72'h0);
    end
    total++;
    if ({inst_rd, data_rd} !== 64'h0) begin
      bad++;
      $display("FAIL reset_readdata got=%h exp=%h", {inst_rd, data_rd}, 64'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    drive_quiet();
  endtask

  task automatic test_inst_read();
    obs_t e;
    @(negedge clk);
    inst_addr = 32'h0000_0100;
    inst_read = 1'b1;
    #1;
    total++;
    if (obs() !== '0) begin
      bad++;
      $display("FAIL inst_pre_grant got=%h exp=%h", obs(), 72'h0);
    end
    @(negedge clk);
    #1;
    e = mk(32'h100, 32'h0, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL inst_grant got=%h exp=%h", obs(), e);
    end
    @(negedge clk);
    @(negedge clk);
    mem_if.readdata = 32'hDEAD_BEEF;
    mem_if.operation_stb = 1'b1;
    #1;
    e = mk(32'h100, 32'h0, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL inst_strobe got=%h exp=%h", obs(), e);
    end
    total++;
    if ({inst_rd, data_rd} !== {32'hDEAD_BEEF, 32'hDEAD_BEEF}) begin
      bad++;
      $display("FAIL inst_readdata got=%h exp=%h", {inst_rd, data_rd}, {32'hDEAD_BEEF, 32'hDEAD_BEEF});
    end
    @(negedge clk);
    drive_quiet();
    #1;
    total++;
    if (obs() !== '0) begin
      bad++;
      $display("FAIL inst_release got=%h exp=%h", obs(), 72'h0);
    end
  endtask

  task automatic test_data_write();
    obs_t e;
    @(negedge clk);
    data_addr = 32'h0000_2000;
    data_wd = 32'h1234_5678;
    data_be = 4'b0011;
    data_write = 1'b1;
    @(negedge clk);
    #1;
    e = mk(32'h2000, 32'h1234_5678, 1'b0, 1'b1, 4'b0011, 1'b0, 1'b0);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL data_grant got=%h exp=%h", obs(), e);
    end
    @(negedge clk);
    mem_if.operation_stb = 1'b1;
    #1;
    e = mk(32'h2000, 32'h1234_5678, 1'b0, 1'b1, 4'b0011, 1'b0, 1'b1);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL data_strobe got=%h exp=%h", obs(), e);
    end
    @(negedge clk);
    drive_quiet();
  endtask

  task automatic test_simultaneous();
    obs_t e;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      inst_addr = 32'h0000_0A00 + 32'(r);
      inst_read = 1'b1;
      data_addr = 32'h0000_B000 + 32'(r);
      data_wd = 32'h0;
      data_be = 4'hF;
      data_read = 1'b1;
      @(negedge clk);
      #1;
      e = mk(data_addr, 32'h0, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      if (r == 1) e = mk(inst_addr, 32'h0, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
`endif
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL tie_winner_round%0d got=%h exp=%h", r, obs(), e);
      end
      @(negedge clk);
      mem_if.operation_stb = 1'b1;
      #1;
      e[1:0] = 2'b01;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      if (r == 1) e[1:0] = 2'b10;
`endif
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL tie_strobe_round%0d got=%h exp=%h", r, obs(), e);
      end
      @(negedge clk);
      drive_quiet();
      #1;
      total++;
      if (obs() !== '0) begin
        bad++;
        $display("FAIL tie_bubble_round%0d got=%h exp=%h", r, obs(), 72'h0);
      end
    end
  endtask

  task automatic test_abort_stray();
    obs_t e;
    @(negedge clk);
    inst_addr = 32'h0000_0300;
    inst_read = 1'b1;
    @(negedge clk);
    #1;
    e = mk(32'h300, 32'h0, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL abort_grant got=%h exp=%h", obs(), e);
    end
    @(negedge clk);
    inst_read = 1'b0;
    #1;
    e = mk(32'h300, 32'h0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL abort_follow got=%h exp=%h", obs(), e);
    end
    @(negedge clk);
    mem_if.operation_stb = 1'b1;
    #1;
    total++;
    if (obs() !== '0) begin
      bad++;
      $display("FAIL stray_strobe got=%h exp=%h", obs(), 72'h0);
    end
    @(negedge clk);
    mem_if.operation_stb = 1'b0;
    data_addr = 32'h0000_4000;
    data_wd = 32'hA5A5_A5A5;
    data_be = 4'hF;
    data_read = 1'b1;
    @(negedge clk);
    #1;
    e = mk(32'h4000, 32'hA5A5_A5A5, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL after_abort_grant got=%h exp=%h", obs(), e);
    end
    @(negedge clk);
    mem_if.readdata = 32'hCAFE_F00D;
    mem_if.operation_stb = 1'b1;
    #1;
    total++;
    if ({data_stb, inst_stb, data_rd} !== {2'b10, 32'hCAFE_F00D}) begin
      bad++;
      $display("FAIL after_abort_strobe got=%h exp=%h", {data_stb, inst_stb, data_rd}, {2'b10, 32'hCAFE_F00D});
    end
    @(negedge clk);
    drive_quiet();
  endtask

  task automatic test_reset_mid_grant();
    obs_t e;
    @(negedge clk);
    data_addr = 32'h0000_5000;
    data_wd = 32'h0000_0011;
    data_be = 4'b1000;
    data_write = 1'b1;
    @(negedge clk);
    #1;
    e = mk(32'h5000, 32'h11, 1'b0, 1'b1, 4'b1000, 1'b0, 1'b0);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL rstmid_grant got=%h exp=%h", obs(), e);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (obs() !== '0) begin
      bad++;
      $display("FAIL rstmid_outputs got=%h exp=%h", obs(), 72'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    data_write = 1'b0;
    mem_if.operation_stb = 1'b1;
    #1;
    total++;
    if (obs() !== '0) begin
      bad++;
      $display("FAIL rstmid_late_strobe got=%h exp=%h", obs(), 72'h0);
    end
    @(negedge clk);
    mem_if.operation_stb = 1'b0;
    inst_addr = 32'h0000_0600;
    inst_read = 1'b1;
    data_addr = 32'h0000_7000;
    data_read = 1'b1;
    @(negedge clk);
    #1;
    e = mk(32'h7000, 32'h11, 1'b1, 1'b0, 4'b1000, 1'b0, 1'b0);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL rstmid_tie_after_reset got=%h exp=%h", obs(), e);
    end
    @(negedge clk);
    mem_if.operation_stb = 1'b1;
    @(negedge clk);
    drive_quiet();
    @(negedge clk);
  endtask

  task automatic test_random_traffic();
    logic [32:0] exp_q[$];
    logic [32:0] got;
    logic [32:0] want;
    obs_t e;
    bit inst_got;
    bit data_got;
    int done_model;
    int done_dut;
    int op;
    inst_got = 1'b0;
    data_got = 1'b0;
    done_model = 0;
    done_dut = 0;
    @(negedge clk);
    drive_quiet();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_owner = 0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    m_last = 1;
`endif
    for (int c = 0; c < 600; c++) begin
      if (c != 0) @(negedge clk);
      if (inst_got || (inst_read && $urandom_range(0, 15) == 0)) inst_read = 1'b0;
      else if (!inst_read && $urandom_range(0, 2) == 0) begin
        inst_read = 1'b1;
        inst_addr = $urandom;
      end
      if (data_got || ((data_read || data_write) && $urandom_range(0, 15) == 0)) begin
        data_read = 1'b0;
        data_write = 1'b0;
      end else if (!(data_read || data_write) && $urandom_range(0, 2) == 0) begin
        op = $urandom_range(0, 7);
        data_read = (op == 0) || (op > 3);
        data_write = (op <= 3);
        data_addr = $urandom;
        data_wd = $urandom;
        data_be = 4'($urandom_range(0, 15));
      end
      mem_if.operation_stb = ($urandom_range(0, 2) == 0);
      mem_if.readdata = $urandom;
      #1;
      e = model_out();
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL rand_outputs cycle=%0d got=%h exp=%h", c, obs(), e);
      end
      total++;
      if ({inst_rd, data_rd} !== {mem_if.readdata, mem_if.readdata}) begin
        bad++;
        $display("FAIL rand_readdata cycle=%0d got=%h exp=%h", c, {inst_rd, data_rd}, {mem_if.readdata, mem_if.readdata});
      end
      if (e[1] || e[0]) begin
        exp_q.push_back({e[0], e[71:40]});
        done_model++;
      end
      if (inst_stb || data_stb) begin
        done_dut++;
        got = {data_stb, mem_if.address};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rand_sb_unexpected cycle=%0d got=%h exp=none", c, got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            bad++;
            $display("FAIL rand_sb_completion cycle=%0d got=%h exp=%h", c, got, want);
          end
        end
      end
      inst_got = e[1];
      data_got = e[0];
      model_tick();
    end
    total++;
    if (done_dut !== done_model || exp_q.size() != 0) begin
      bad++;
      $display("FAIL rand_completion_count got=%0d exp=%0d left=%0d", done_dut, done_model, exp_q.size());
    end
    @(negedge clk);
    drive_quiet();
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    inst_addr = 32'h0;
    data_addr = 32'h0;
    data_wd = 32'h0;
    data_be = 4'h0;
    drive_quiet();
    test_reset();
    test_inst_read();
    test_data_write();
    test_simultaneous();
    test_abort_stray();
    test_reset_mid_grant();
    test_random_traffic();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod_mem_arbiter.md
# mod_mem_arbiter

Two-client arbiter that shares the single main-memory port between the instruction cache and the data cache. It sits directly downstream of the data cache's memory-side interface (and the instruction cache's equivalent interface) and directly upstream of main memory. It grants the port to one cache at a time and holds the grant until memory signals completion. It forwards the granted client's request signals to memory and routes the completion strobe back to that client only.

## Interface
Parameters (widths come from `system_defines.svh`):
- `XLEN`, 32, address/data width (global define).
- `BYTEENABLE_WIDTH`, 4, byte-enable width (global define).

Ports. One clock; reset is synchronous and active-high.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous active-high reset.
- `inst_address_i`  in  `XLEN`  I-cache memory address.
- `inst_read_i`  in  1  I-cache read request (level, held until strobe).
- `inst_readdata_o`  out  `XLEN`  read data to I-cache.
- `inst_operation_stb_o`  out  1  I-cache operation complete.
- `data_address_i`  in  `XLEN`  D-cache memory address.
- `data_writedata_i`  in  `XLEN`  D-cache write data.
- `data_read_i`  in  1  D-cache read request (level).
- `data_write_i`  in  1  D-cache write request (level).
- `data_byteenable_i`  in  `BYTEENABLE_WIDTH`  D-cache byte enables.
- `data_readdata_o`  out  `XLEN`  read data to D-cache.
- `data_operation_stb_o`  out  1  D-cache operation complete.
- `memory_readdata_i`  in  `XLEN`  main-memory read data.
- `memory_operation_stb_i`  in  1  main-memory operation complete.
- `memory_address_o`  out  `XLEN`  address to memory.
- `memory_writedata_o`  out  `XLEN`  write data to memory.
- `memory_read_o`  out  1  read request to memory.
- `memory_write_o`  out  1  write request to memory.
- `memory_byteenable_o`  out  `BYTEENABLE_WIDTH`  byte enables to memory.

## Operation
State machine: IDLE, GRANT_INST, GRANT_DATA. The state is registered.

- **Requests.** The I-cache requests when `inst_read_i` is high. The D-cache requests when `data_read_i | data_write_i` is high.
- **IDLE.**
  - Memory outputs are all zero.
  - Both strobes are 0.
  - On any request, the state moves to the matching GRANT state. Ties are resolved by the arbitration policy (see Configuration).
- **GRANT_INST.**
  - Memory address = `inst_address_i`; read = `inst_read_i`; write = 0.
  - Byteenable = all ones; writedata = 0.
- **GRANT_DATA.**
  - All memory outputs follow the `data_*` inputs combinationally.
- **Strobe routing.** In a GRANT state, `memory_operation_stb_i` is forwarded combinationally to the granted client's strobe only. The next state is IDLE.
- **Abort.** If the granted client drops its request before the strobe arrives, the next state is IDLE. Memory outputs follow the (now low) request immediately.
- **Read data.** `memory_readdata_i` is broadcast unregistered to both `*_readdata_o`. Only the strobe qualifies it.
- **Stray strobe.** `memory_operation_stb_i` in IDLE is ignored; no client strobe is raised.
- **Both read and write from the D-cache.** Forwarded as-is; the arbiter does not check or correct it.
- **Client contract.** A client deasserts its request in the cycle after it receives its strobe.

## Timing
- **Reset.** State = IDLE and the round-robin pointer = INST. All outputs are 0 in the cycle after `rst_i` is high.
- **Reset mid-grant.** The grant is dropped, the in-flight memory operation is abandoned, and a late memory strobe is ignored.
- **Grant latency.**
  - Request first seen high at cycle N in IDLE → memory request outputs valid at cycle N+1.
- **Completion.** Strobe at cycle M:
  - Client strobe at cycle M, zero latency.
  - IDLE at cycle M+1.
  - The next grant's outputs are valid at cycle M+2 at the earliest.
- **Throughput.** One idle bubble between operations. A memory strobe in the same cycle a grant begins is valid.

## Configuration
- **`MEM_ARBITER_ROUND_ROBIN_EN` defined.**
  - On a simultaneous request, the client not served last wins.
  - A one-bit `last_grant` register updates on each completed or aborted grant.
- **`MEM_ARBITER_ROUND_ROBIN_EN` undefined.**
  - Fixed priority: data over instruction.
  - No `last_grant` register.

## Structure
- **Shared memory package.** Holds the `arb_state_e` enum (IDLE, GRANT_INST, GRANT_DATA) and the `arb_client_e` enum (INST, DATA).
- **Mux sub-module.** Output muxing goes in one sub-module, `mod_mem_arbiter_mux`: purely combinational, selected by state.
- **Top level.** Keeps the FSM and arbitration.

## Test plan
1. **Reset.** Hold `rst_i` for 2 cycles → all outputs 0; state IDLE.
2. **Single instruction read.**
   - Stimulus: `inst_read_i`=1, address 0x0000_0100; memory strobes 3 cycles later with readdata 0xDEAD_BEEF.
   - Required: `memory_read_o`=1 with address 0x100 one cycle after the request; `inst_operation_stb_o` pulses with `inst_readdata_o`=0xDEAD_BEEF; `data_operation_stb_o` stays 0.
3. **Data write.**
   - Stimulus: address 0x2000, writedata 0x1234_5678, byteenable 4'b0011.
   - Required: memory outputs match exactly; `memory_read_o`=0; the strobe is routed to the D-cache only.
4. **Simultaneous requests.**
   - Stimulus: both clients request in the same cycle, repeated for two rounds.
   - Fixed priority: DATA, DATA.
   - Round robin: DATA then INST, with one IDLE bubble between.
5. **Abort and stray strobe.**
   - Stimulus: the I-cache drops `inst_read_i` mid-grant; a strobe then arrives while IDLE.
   - Required: no client strobe; the next D-cache request is granted normally.
6. **Reset mid-grant.**
   - Stimulus: `rst_i` asserted during GRANT_DATA.
   - Required: all outputs 0 on the next cycle; a memory strobe one cycle later is ignored.
